// File: rtl/regfile_signext.sv
`default_nettype none
// ============================================================================
// Module  : regfile_signext
// Brief   : Decode-stage register file (2R/1W, write-through bypass) plus
//           16-to-32-bit immediate sign extender.
// Revision: 1.0
// ============================================================================
module regfile_signext #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int IMM_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] read_addr_1,
  input  logic [ADDR_WIDTH-1:0] read_addr_2,
  input  logic [ADDR_WIDTH-1:0] write_addr,
  input  logic [DATA_WIDTH-1:0] write_data,
  input  logic                  write_enabled,
  output logic [DATA_WIDTH-1:0] data_1,
  output logic [DATA_WIDTH-1:0] data_2,
  input  logic [IMM_WIDTH-1:0]  imm_in,
  output logic [DATA_WIDTH-1:0] imm_out
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] regs_q [DEPTH];
  logic [DATA_WIDTH-1:0] regs_d [DEPTH];
  logic                  wr_live;

  // A write only takes effect (and only bypasses) when it is not squashed by
  // reset and does not target the hardwired zero register.
  assign wr_live = write_enabled && !rst && (write_addr != '0);

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      regs_d[i] = regs_q[i];
    end
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        regs_d[i] = '0;
      end
    end else if (wr_live) begin
      regs_d[write_addr] = write_data;
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < DEPTH; i++) begin
      regs_q[i] <= regs_d[i];
    end
  end

  always_comb begin
    data_1 = '0;
    if (read_addr_1 != '0) begin
      if (wr_live && (read_addr_1 == write_addr)) begin
        data_1 = write_data;
      end else begin
        data_1 = regs_q[read_addr_1];
      end
    end
  end

  always_comb begin
    data_2 = '0;
    if (read_addr_2 != '0) begin
      if (wr_live && (read_addr_2 == write_addr)) begin
        data_2 = write_data;
      end else begin
        data_2 = regs_q[read_addr_2];
      end
    end
  end

  assign imm_out = {{(DATA_WIDTH - IMM_WIDTH){imm_in[IMM_WIDTH-1]}}, imm_in};

endmodule
`default_nettype wire

// File: tb/tb_regfile_signext.sv
`default_nettype none
// Bench for regfile_signext: directed sequences, a sign-extension vector
// table, and randomized traffic against an array-based reference model.
module tb_regfile_signext;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  read_addr_1, read_addr_2, write_addr;
  logic [31:0] write_data;
  logic        write_enabled;
  logic [31:0] data_1, data_2;
  logic [15:0] imm_in;
  logic [31:0] imm_out;

  int n_total = 0;
  int n_pass  = 0;

  regfile_signext dut (
    .clk          (clk),
    .rst          (rst),
    .read_addr_1  (read_addr_1),
    .read_addr_2  (read_addr_2),
    .write_addr   (write_addr),
    .write_data   (write_data),
    .write_enabled(write_enabled),
    .data_1       (data_1),
    .data_2       (data_2),
    .imm_in       (imm_in),
    .imm_out      (imm_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] imm;
    logic        rst_v;
    logic [31:0] exp;
  } sx_vec_t;

  sx_vec_t     vecs [8];
  logic [31:0] model [32];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{16'h7FFF, 1'b0, 32'h0000_7FFF};
    vecs[1] = '{16'h8000, 1'b0, 32'hFFFF_8000};
    vecs[2] = '{16'hFFFF, 1'b0, 32'hFFFF_FFFF};
    vecs[3] = '{16'h0000, 1'b0, 32'h0000_0000};
    vecs[4] = '{16'h7FFF, 1'b1, 32'h0000_7FFF};
    vecs[5] = '{16'h8000, 1'b1, 32'hFFFF_8000};
    vecs[6] = '{16'hFFFF, 1'b1, 32'hFFFF_FFFF};
    vecs[7] = '{16'h0000, 1'b1, 32'h0000_0000};

    rst = 1'b1; write_enabled = 1'b0; write_addr = '0; write_data = '0;
    read_addr_1 = '0; read_addr_2 = '0; imm_in = '0;
    #3;
    tick();
    rst = 1'b0;

    // Reset clears a previously written register
    write_enabled = 1'b1; write_addr = 5'd5; write_data = 32'hDEAD_BEEF;
    tick();
    write_enabled = 1'b0; read_addr_1 = 5'd5; #1;
    check("pre_reset_r5", data_1, 32'hDEAD_BEEF);
    rst = 1'b1;
    tick();
    rst = 1'b0; read_addr_1 = 5'd5; read_addr_2 = 5'd31; #1;
    check("reset_r5", data_1, 32'h0);
    check("reset_r31", data_2, 32'h0);

    // Write then read on consecutive edges
    write_enabled = 1'b1; write_addr = 5'd8; write_data = 32'h1234_5678;
    tick();
    write_addr = 5'd9; write_data = 32'hCAFE_F00D;
    tick();
    write_enabled = 1'b0; read_addr_1 = 5'd8; read_addr_2 = 5'd9; #1;
    check("rd_r8_p1", data_1, 32'h1234_5678);
    check("rd_r9_p2", data_2, 32'hCAFE_F00D);
    read_addr_2 = 5'd8; #1;
    check("same_p1", data_1, 32'h1234_5678);
    check("same_p2", data_2, 32'h1234_5678);

    // r0 immutable, no bypass to r0
    write_enabled = 1'b1; write_addr = 5'd0; write_data = 32'hFFFF_FFFF;
    read_addr_1 = 5'd0; read_addr_2 = 5'd0; #1;
    check("r0_during_p1", data_1, 32'h0);
    check("r0_during_p2", data_2, 32'h0);
    tick();
    write_enabled = 1'b0; #1;
    check("r0_after_p1", data_1, 32'h0);
    check("r0_after_p2", data_2, 32'h0);

    // Bypass
    write_enabled = 1'b1; write_addr = 5'd3; write_data = 32'h1;
    tick();
    write_addr = 5'd3; write_data = 32'h55; read_addr_2 = 5'd3; read_addr_1 = 5'd8; #1;
    check("bypass_p2", data_2, 32'h55);
    check("bypass_other_p1", data_1, 32'h1234_5678);
    read_addr_1 = 5'd3; #1;
    check("bypass_p1", data_1, 32'h55);
    tick();
    write_enabled = 1'b0; #1;
    check("bypass_after", data_2, 32'h55);

    // Reset beats a simultaneous write and suppresses bypass
    write_enabled = 1'b1; write_addr = 5'd3; write_data = 32'h77; rst = 1'b1; #1;
    check("rst_no_bypass", data_2, 32'h55);
    tick();
    rst = 1'b0; write_enabled = 1'b0; #1;
    check("rst_prio_r3", data_2, 32'h0);

    // Write disabled
    write_enabled = 1'b0; write_addr = 5'd7; write_data = 32'hAAAA_5555;
    tick();
    read_addr_1 = 5'd7; #1;
    check("we0_r7", data_1, 32'h0);

    // Sign extension table
    for (int i = 0; i < 8; i++) begin
      rst = vecs[i].rst_v; imm_in = vecs[i].imm; #1;
      check($sformatf("sext_%0d", i), imm_out, vecs[i].exp);
      if (vecs[i].rst_v) begin
        tick();
        check($sformatf("sext_clk_%0d", i), imm_out, vecs[i].exp);
      end
    end

    // Randomized traffic against the reference model (rst is 1 here)
    rst = 1'b1;
    tick();
    for (int i = 0; i < 32; i++) model[i] = 32'h0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      logic [31:0] e1, e2, sx;
      rst           = ($urandom_range(0, 31) == 0);
      write_enabled = $urandom_range(0, 1) == 1;
      write_addr    = 5'($urandom_range(0, 31));
      write_data    = $urandom;
      read_addr_1   = ($urandom_range(0, 3) == 0) ? write_addr : 5'($urandom_range(0, 31));
      read_addr_2   = ($urandom_range(0, 3) == 0) ? write_addr : 5'($urandom_range(0, 31));
      imm_in        = 16'($urandom);
      #1;
      e1 = model[read_addr_1];
      e2 = model[read_addr_2];
      if (write_enabled && !rst && write_addr != 0) begin
        if (read_addr_1 == write_addr) e1 = write_data;
        if (read_addr_2 == write_addr) e2 = write_data;
      end
      if (read_addr_1 == 0) e1 = 32'h0;
      if (read_addr_2 == 0) e2 = 32'h0;
      sx = 32'(int'($signed(imm_in)));
      check("rand_p1", data_1, e1);
      check("rand_p2", data_2, e2);
      check("rand_sext", imm_out, sx);
      tick();
      if (rst) begin
        for (int i = 0; i < 32; i++) model[i] = 32'h0;
      end else if (write_enabled && write_addr != 0) begin
        model[write_addr] = write_data;
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
